// File: rtl/control_sequencer.sv
// Moore control sequencer: timed strobes for fetch (T0-T2) and reg-reg execute (T3-T6).
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes trap to HALT and raise fault.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int RSW  = 4,
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Mem_ready,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  alu_op,
  output logic            Run,
  output logic            fault
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t         state, next_state;
  logic [OPW-1:0] opcode;
  logic [RSW-1:0] ra, rb, rc;
  logic           is_alu, is_muldiv, is_halt, trap;
  logic           unused_ir_bits;

  assign opcode         = IR[31 -: OPW];
  assign ra             = IR[31-OPW -: RSW];
  assign rb             = IR[31-OPW-RSW -: RSW];
  assign rc             = IR[31-OPW-2*RSW -: RSW];
  assign unused_ir_bits = ^IR[31-OPW-3*RSW:0];

  function automatic logic [NREG-1:0] onehot(input logic [RSW-1:0] sel);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << sel;
  endfunction

  always_comb begin
    is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    is_alu    = is_muldiv || (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                             OP_SHR, OP_SHL, OP_ROR, OP_ROL});
    is_halt   = (opcode == OP_HALT);
  end

`ifdef ILLEGAL_TRAP_EN
  localparam logic [OPW-1:0] OP_NOP = OPW'(5'b11000);
  logic fault_q;

  assign trap  = !(is_alu || is_halt || (opcode == OP_NOP));
  assign fault = fault_q;

  // Sticky trap flag, raised on the decode cycle that sends an illegal opcode to HALT
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)                  fault_q <= 1'b0;
    else if (state == T3 && trap) fault_q <= 1'b1;
  end
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;
`endif

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next_state;
  end

  // Instruction boundaries (nop decode, end of T5/T6) are the only places Stop is seen
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Start) next_state = T0;
      T0:   next_state = T1;
      T1:   next_state = Mem_ready ? T2 : T1W;
      T1W:  if (Mem_ready) next_state = T2;
      T2:   next_state = T3;
      T3: begin
        if (is_alu)              next_state = T4;
        else if (is_halt || trap) next_state = HALT;
        else                     next_state = Stop ? IDLE : T0;
      end
      T4:   next_state = T5;
      T5: begin
        if (is_muldiv) next_state = T6;
        else           next_state = Stop ? IDLE : T0;
      end
      T6:   next_state = Stop ? IDLE : T0;
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    Run      = (state != IDLE) && (state != HALT);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      // Non-ALU opcodes spend this cycle decoding with all strobes idle
      T3: begin
        if (is_alu) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end
      end
      T4: begin
        Rout   = onehot(rc);
        Zin    = 1'b1;
        alu_op = opcode;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = onehot(ra);
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: a per-instruction cycle
// schedule model predicts every output each cycle.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, HIin, LOin, Run, fault;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .Start(Start), .Stop(Stop),
    .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .Run(Run), .fault(fault)
  );

  always #5 Clock = ~Clock;

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_ZIN    = 14'h0400;
  localparam logic [13:0] S_ZLOW   = 14'h0200;
  localparam logic [13:0] S_ZHIGH  = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_READ   = 14'h0040;
  localparam logic [13:0] S_MDRIN  = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010;
  localparam logic [13:0] S_IRIN   = 14'h0008;
  localparam logic [13:0] S_YIN    = 14'h0004;
  localparam logic [13:0] S_HIIN   = 14'h0002;
  localparam logic [13:0] S_LOIN   = 14'h0001;

  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NOP  = 5'b11000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic        st;
    logic [52:0] exp;
  } cyc_t;

  cyc_t       plan[$];
  int         checks = 0;
  int         errors = 0;
  logic       fault_exp = 1'b0;
  logic       halted = 1'b0;
  logic [4:0] plain_ops [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                5'b00111, 5'b01000, 5'b01001, 5'b01010};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [52:0] observed();
    return {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
            MDRout, IRin, Yin, HIin, LOin, Rin, Rout, alu_op, Run, fault};
  endfunction

  function automatic bit is_muldiv_op(input logic [4:0] op);
    return (op == OPC_MUL) || (op == OPC_DIV);
  endfunction

  function automatic bit is_alu_op(input logic [4:0] op);
    return is_muldiv_op(op) || (op >= 5'b00011 && op <= 5'b01010);
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return is_alu_op(op) || op == OPC_NOP || op == OPC_HALT;
  endfunction

  function automatic logic [4:0] rand_op();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 9);
    if (r < 6) return plain_ops[$urandom_range(0, 7)];
    if (r == 6) return OPC_MUL;
    if (r == 7) return OPC_DIV;
    if (r == 8 || TRAP) return OPC_NOP;
    do op = 5'($urandom_range(0, 31)); while (is_legal(op));
    return op;
  endfunction

  task automatic push(input logic [31:0] ir, input logic mr, input logic stp,
                      input logic st, input logic [13:0] s, input logic [15:0] rin,
                      input logic [15:0] rout, input logic [4:0] alu, input logic run);
    cyc_t c;
    c.ir  = ir;
    c.mr  = mr;
    c.stp = stp;
    c.st  = st;
    c.exp = {s, rin, rout, alu, run, fault_exp};
    plan.push_back(c);
  endtask

  task automatic add_idle(input logic st);
    push($urandom, rbit(), rbit(), st, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic add_halt_cycles(input int n);
    for (int k = 0; k < n; k++) push($urandom, rbit(), rbit(), rbit(), '0, '0, '0, '0, 1'b0);
  endtask

  // One instruction as a list of per-cycle expectations; stop_end is Stop at its boundary
  task automatic add_instr(input logic [31:0] instr, input int waits, input logic stop_end);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27];
    ra = instr[26:23];
    rb = instr[22:19];
    rc = instr[18:15];
    push($urandom, rbit(), rbit(), rbit(), S_PCOUT | S_MARIN | S_INCPC | S_ZIN, '0, '0, '0, 1'b1);
    push($urandom, waits == 0, rbit(), rbit(), S_ZLOW | S_PCIN | S_READ | S_MDRIN, '0, '0, '0, 1'b1);
    for (int k = 0; k < waits; k++)
      push($urandom, k == waits - 1, rbit(), rbit(), S_READ | S_MDRIN, '0, '0, '0, 1'b1);
    push($urandom, rbit(), rbit(), rbit(), S_MDROUT | S_IRIN, '0, '0, '0, 1'b1);
    if (is_alu_op(op)) begin
      push(instr, rbit(), rbit(), rbit(), S_YIN, '0, 16'(1) << rb, '0, 1'b1);
      push(instr, rbit(), rbit(), rbit(), S_ZIN, '0, 16'(1) << rc, op, 1'b1);
      if (is_muldiv_op(op)) begin
        push(instr, rbit(), rbit(), rbit(), S_ZLOW | S_LOIN, '0, '0, '0, 1'b1);
        push(instr, rbit(), stop_end, rbit(), S_ZHIGH | S_HIIN, '0, '0, '0, 1'b1);
      end else begin
        push(instr, rbit(), stop_end, rbit(), S_ZLOW, 16'(1) << ra, '0, '0, 1'b1);
      end
    end else if (op == OPC_HALT || (TRAP && !is_legal(op))) begin
      push(instr, rbit(), rbit(), rbit(), '0, '0, '0, '0, 1'b1);
      if (op != OPC_HALT) fault_exp = 1'b1;
      halted = 1'b1;
    end else begin
      push(instr, rbit(), stop_end, rbit(), '0, '0, '0, '0, 1'b1);
    end
  endtask

  task automatic drive_cycle(input cyc_t c, output logic [52:0] obs);
    @(negedge Clock);
    IR        = c.ir;
    Mem_ready = c.mr;
    Stop      = c.stp;
    Start     = c.st;
    #1 obs = observed();
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Start = 1'b0;
    Stop  = 1'b0;
    #2 clear = 1'b0;
    @(negedge Clock);
    clear     = 1'b1;
    fault_exp = 1'b0;
    halted    = 1'b0;
    plan.delete();
  endtask

  function automatic logic [31:0] rand_instr(input logic [4:0] op);
    return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
  endfunction

  task automatic test_reset();
    logic [52:0] obs;
    cyc_t c;
    int i;
    #5 clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      Start = 1'b1;
      Mem_ready = rbit();
      IR = $urandom;
      #1 obs = observed();
      checks++;
      if (obs !== 53'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", k, obs, 53'd0);
      end
    end
    @(negedge Clock);
    Start = 1'b0;
    clear = 1'b1;
    #1 obs = observed();
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, 53'd0);
    end
    add_idle(1'b0);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL idle cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_add();
    logic [52:0] obs;
    cyc_t c;
    int i;
    add_idle(1'b0);
    add_idle(1'b1);
    add_instr(32'h1891_8000, 0, 1'b1);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL add cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_mem_wait();
    logic [52:0] obs;
    cyc_t c;
    int i;
    add_idle(1'b1);
    add_instr(32'h1891_8000, 3, 1'b0);
    add_instr(rand_instr(OPC_DIV), 1, 1'b1);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL mem_wait cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_mul();
    logic [52:0] obs;
    cyc_t c;
    int i;
    add_idle(1'b1);
    add_instr(32'h7833_8000, 0, 1'b1);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL mul cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_stop();
    logic [52:0] obs;
    cyc_t c;
    int i;
    add_idle(1'b1);
    add_instr(32'hC000_0000, 0, 1'b0);
    add_instr(32'h1891_8000, 0, 1'b1);
    add_idle(1'b0);
    add_idle(1'b1);
    add_instr(32'hC000_0000, 0, 1'b1);
    add_idle(1'b0);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL stop cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [52:0] obs;
    cyc_t c;
    int i;
    logic stop_end;
    add_idle(1'b1);
    for (int n = 0; n < 40; n++) begin
      stop_end = ($urandom_range(0, 3) == 0) || (n == 39);
      add_instr(rand_instr(rand_op()),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, stop_end);
      if (stop_end) begin
        repeat ($urandom_range(0, 2)) add_idle(1'b0);
        if (n < 39) add_idle(1'b1);
      end
    end
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_illegal();
    logic [52:0] obs;
    cyc_t c;
    int i;
    add_idle(1'b1);
    add_instr(32'hF800_0000, 0, 1'b0);
    if (halted) add_halt_cycles(4);
    else add_instr(32'h1891_8000, 0, 1'b1);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
    checks++;
    if (fault !== TRAP) begin
      errors++;
      $display("FAIL illegal_fault: got %b expected %b", fault, TRAP);
    end
  endtask

  task automatic test_async_reset();
    logic [52:0] obs;
    cyc_t c;
    int i;
    @(negedge Clock);
    #2 clear = 1'b0;
    #1 obs = observed();
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("FAIL async_reset_first: got %h expected %h", obs, 53'd0);
    end
    @(negedge Clock);
    Start = 1'b0;
    clear = 1'b1;
    fault_exp = 1'b0;
    halted = 1'b0;
    add_idle(1'b1);
    add_instr(32'h7833_8000, 1, 1'b0);
    for (i = 0; i < 7; i++) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", i, obs, c.exp);
      end
    end
    plan.delete();
    @(negedge Clock);
    #2 clear = 1'b0;
    Start = 1'b1;
    #1 obs = observed();
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("FAIL async_mid_instr: got %h expected %h", obs, 53'd0);
    end
    @(posedge Clock);
    #1 obs = observed();
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("FAIL async_held: got %h expected %h", obs, 53'd0);
    end
    @(negedge Clock);
    Start = 1'b0;
    clear = 1'b1;
    add_idle(1'b0);
    add_idle(1'b1);
    add_instr(rand_instr(OPC_NOP), 0, 1'b1);
    add_idle(1'b0);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL async_post cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_halt();
    logic [52:0] obs;
    cyc_t c;
    int i;
    apply_reset();
    add_idle(1'b1);
    add_instr(32'hD800_0000, 1, 1'b0);
    add_halt_cycles(5);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, obs);
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL halt cycle %0d: got %h expected %h", i, obs, c.exp);
      end
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_mem_wait();
    test_mul();
    test_stop();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
